// File: rtl/clk_step_ctrl_pkg.sv
// Shared constants for the core clock-enable controller: mode encoding,
// manual-code threshold and the decade divisor table.
package clk_step_pkg;

  localparam int unsigned DIV_W      = 27;
  localparam int unsigned MANUAL_MIN = 12;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_e;

  // Board-clock cycles per enable pulse for each rate code; manual codes
  // return 1 so the divider arithmetic stays well defined.
  function automatic logic [DIV_W-1:0] div_of(input int unsigned code);
    case (code)
      0:       div_of = 27'd100_000_000;
      1:       div_of = 27'd10_000_000;
      2:       div_of = 27'd1_000_000;
      3:       div_of = 27'd100_000;
      4:       div_of = 27'd10_000;
      5:       div_of = 27'd1_000;
      6:       div_of = 27'd100;
      7:       div_of = 27'd10;
      8:       div_of = 27'd5;
      9:       div_of = 27'd4;
      10:      div_of = 27'd2;
      default: div_of = 27'd1;
    endcase
  endfunction

endpackage

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], raw};
  end

  // Accept a new level only after it has differed from db for DB_CYCLES
  // consecutive samples; any bounce back to db restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt  <= '0;
        db   <= sync[1];
        rise <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Core clock-enable generator: free-runs at a decade rate or issues single
// steps from the debounced button. Never touches the clock itself.
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned SEL_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
  input  logic             step_btn,
  output logic             clk_en,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             step_db,
  output logic [1:0]       mode
);

  mode_e            state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, cnt_adv, div_m1;
  logic [SEL_W-1:0] sel_q;
  logic             en_n, wrap, run_ok, sel_chg, step_rise;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk  (clk),
    .reset(reset),
    .raw  (step_btn),
    .db   (step_db),
    .rise (step_rise)
  );

  assign run_ok  = run && (32'(sel) < MANUAL_MIN);
  assign sel_chg = (sel != sel_q);
  assign div_m1  = div_of(32'(sel)) - DIV_W'(1);
  // cnt holds the position of the *next* cycle, so the enable can be
  // registered and still line up with the terminal cycle.
  assign wrap    = (cnt == div_m1);
  assign cnt_adv = wrap ? '0 : cnt + DIV_W'(1);
  assign mode    = state;

  // Next-state, divider and enable decode; divider rests at 0 outside RUN.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    en_n    = 1'b0;
    case (state)
      MODE_IDLE: begin
        if (run_ok) begin
          state_n = MODE_RUN;
          en_n    = wrap;
          cnt_n   = cnt_adv;
        end else if (step_rise) begin
          state_n = MODE_STEP;
          en_n    = 1'b1;
        end
      end
      MODE_RUN: begin
        if (!run_ok) begin
          state_n = MODE_IDLE;
        end else if (!sel_chg) begin
          en_n  = wrap;
          cnt_n = cnt_adv;
        end
        // a rate change leaves cnt_n at 0: one silent clearing cycle
      end
      MODE_STEP: state_n = MODE_IDLE;
      default:   state_n = MODE_IDLE;
    endcase
  end

  // State, divider, registered enable and the issued-pulse counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MODE_IDLE;
      cnt      <= '0;
      clk_en   <= 1'b0;
      tick_cnt <= '0;
      sel_q    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      clk_en   <= en_n;
      tick_cnt <= tick_cnt + CNT_W'(clk_en);
      sel_q    <= sel;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: table vectors, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_clk_step_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sel = '0;
  logic       run = 1'b0;
  logic       step_btn = 1'b0;
  logic       clk_en;
  logic [3:0] tick_cnt;
  logic       step_db;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;

  int divs[16] = '{100000000, 10000000, 1000000, 100000, 10000, 1000, 100,
                   10, 5, 4, 2, 1, 0, 0, 0, 0};

  clk_step_ctrl #(.CNT_W(4), .DB_CYCLES(DB), .SEL_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .run     (run),
    .step_btn(step_btn),
    .clk_en  (clk_en),
    .tick_cnt(tick_cnt),
    .step_db (step_db),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({clk_en, mode, tick_cnt, step_db});
  endfunction

  // Reset with inputs preset; leaves time just after a falling edge so the
  // next rising edge is the first one after release.
  task automatic do_reset(input logic [3:0] s, input logic r, input logic b);
    sel = s; run = r; step_btn = b;
    reset = 1'b1;
    #1;
    chk("reset_state", outs(), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int         m_k, m_anchor, m_prev_sel;
  logic [1:0] m_mode;
  logic       m_en, m_db, m_rise;
  logic [3:0] m_tick;
  logic       hist[$];

  task automatic model_reset();
    m_k = 0; m_anchor = 0; m_prev_sel = 0;
    m_mode = 2'd0; m_en = 1'b0; m_db = 1'b0; m_rise = 1'b0; m_tick = '0;
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
  endtask

  // One rising edge: step_db flips once the DB samples seen two edges back
  // all disagree with it; RUN pulses fall on multiples of DIV past an anchor.
  task automatic model_edge(input int s, input logic r, input logic b);
    logic run_ok, chg, all_diff, new_db, new_rise, new_en;
    logic [1:0] new_mode;
    int d;
    m_k++;
    hist.push_back(b);
    all_diff = 1'b1;
    for (int i = 2; i <= DB + 1; i++)
      if (hist[hist.size() - 1 - i] == m_db) all_diff = 1'b0;
    new_db   = all_diff ? ~m_db : m_db;
    new_rise = all_diff && !m_db;
    while (hist.size() > DB + 2) void'(hist.pop_front());

    run_ok   = r && (s < 12);
    chg      = (s != m_prev_sel);
    d        = run_ok ? divs[s] : 1;
    new_mode = m_mode;
    new_en   = 1'b0;
    case (m_mode)
      2'd0: begin
        if (run_ok) begin
          new_mode = 2'd1;
          m_anchor = m_k - 1;
          new_en   = ((m_k - m_anchor) % d) == 0;
        end else if (m_rise) begin
          new_mode = 2'd2;
          new_en   = 1'b1;
        end
      end
      2'd1: begin
        if (!run_ok) new_mode = 2'd0;
        else if (chg) m_anchor = m_k;
        else new_en = ((m_k - m_anchor) % d) == 0;
      end
      default: new_mode = 2'd0;
    endcase
    m_tick     = m_tick + 4'(m_en);
    m_en       = new_en;
    m_mode     = new_mode;
    m_db       = new_db;
    m_rise     = new_rise;
    m_prev_sel = s;
  endtask

  typedef struct {
    logic [3:0] sel;
    logic       run;
    int         n;
    int         exp_pulses;
    logic [3:0] exp_tick;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int   pulses, p_found, rises, steps, step_cyc, fall_cyc, rel_pulses;
    int   sel_hold, btn_hold;
    logic [6:0] rc_pat;
    logic prev_db, exp_en, ok;

    vecs[0] = '{4'd11, 1'b1, 10, 10, 4'd10};
    vecs[1] = '{4'd8,  1'b1, 50, 10, 4'd10};
    vecs[2] = '{4'd11, 1'b1, 17, 17, 4'd1};
    vecs[3] = '{4'd9,  1'b1, 20, 5,  4'd5};
    vecs[4] = '{4'd10, 1'b1, 9,  4,  4'd4};
    vecs[5] = '{4'd6,  1'b1, 99, 0,  4'd0};
    vecs[6] = '{4'd6,  1'b1, 100, 1, 4'd1};
    vecs[7] = '{4'd12, 1'b1, 10, 0,  4'd0};
    vecs[8] = '{4'd15, 1'b1, 5,  0,  4'd0};
    vecs[9] = '{4'd3,  1'b0, 10, 0,  4'd0};

    // ---- table vectors: steady inputs for n cycles, then stop ----
    foreach (vecs[v]) begin
      do_reset(vecs[v].sel, vecs[v].run, 1'b0);
      ok = vecs[v].run && (vecs[v].sel < 12);
      pulses = 0;
      for (int i = 0; i < vecs[v].n; i++) begin
        @(posedge clk); #1;
        exp_en = ok && ((i % divs[vecs[v].sel]) == divs[vecs[v].sel] - 1);
        chk($sformatf("vec%0d_en", v), 32'(clk_en), 32'(exp_en));
        chk($sformatf("vec%0d_mode", v), 32'(mode), ok ? 32'd1 : 32'd0);
        if (clk_en) pulses++;
      end
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      run = 1'b0; sel = 4'd12;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_stop_en", v), 32'(clk_en), 0);
      chk($sformatf("vec%0d_stop_mode", v), 32'(mode), 0);
      chk($sformatf("vec%0d_tick", v), 32'(tick_cnt), 32'(vecs[v].exp_tick));
    end

    // ---- rate change DIV=10 -> DIV=2, three cycles after a pulse ----
    do_reset(4'd7, 1'b1, 1'b0);
    p_found = 0;
    for (int i = 0; i < 30 && p_found == 0; i++) begin
      @(posedge clk); #1;
      if (clk_en) p_found = 1;
    end
    chk("rc_first_pulse", p_found, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rc_pre_en", 32'(clk_en), 0);
    end
    sel = 4'd10;
    rc_pat = 7'b1010100;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rc_en%0d", i), 32'(clk_en), 32'(rc_pat[i]));
      chk("rc_mode", 32'(mode), 1);
    end

    // ---- manual step with bounce, then release ----
    do_reset(4'd12, 1'b0, 1'b0);
    rises = 0; steps = 0; pulses = 0; step_cyc = -1; fall_cyc = -1; rel_pulses = 0;
    prev_db = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step_btn = (c < 20) ? (c != 1) : 1'b0;
      @(posedge clk); #1;
      if (step_db && !prev_db) rises++;
      if (!step_db && prev_db) fall_cyc = c;
      prev_db = step_db;
      if (mode == 2'd2) begin steps++; step_cyc = c; end
      if (clk_en) begin
        pulses++;
        if (c >= 20) rel_pulses++;
      end
      chk("step_en_vs_mode", 32'(clk_en), 32'(mode == 2'd2));
    end
    chk("step_db_rises", rises, 1);
    chk("step_cycles", steps, 1);
    chk("step_pulses", pulses, 1);
    chk("step_at_cycle", step_cyc, 8);
    chk("step_db_fall_cycle", fall_cyc, 25);
    chk("step_release_pulses", rel_pulses, 0);
    chk("step_tick", 32'(tick_cnt), 1);

    // ---- step button ignored while running DIV=4 ----
    do_reset(4'd9, 1'b1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step_btn = (c >= 5 && c <= 20);
      @(posedge clk); #1;
      chk("ign_en", 32'(clk_en), 32'((c % 4) == 3));
      chk("ign_mode", 32'(mode), 1);
    end
    run = 1'b0; sel = 4'd12;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("ign_no_queued_step", 32'({clk_en, mode}), 0);
    end
    chk("ign_tick", 32'(tick_cnt), 10);

    // ---- asynchronous reset mid-operation ----
    do_reset(4'd11, 1'b1, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_outs", outs(), 32'({1'b1, 2'd1, 4'd11, 1'b1}));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_idle", 32'(mode), 0);
    @(posedge clk); #1;
    chk("rst_first_edge", 32'({clk_en, mode}), 32'({1'b1, 2'd1}));

    // ---- randomized run against the reference model ----
    do_reset(4'd0, 1'b1, 1'b0);
    model_reset();
    sel_hold = 0; btn_hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (sel_hold == 0) begin
        sel = ($urandom_range(9) < 7) ? 4'($urandom_range(15, 7)) : 4'($urandom_range(15));
        sel_hold = $urandom_range(40, 1);
      end
      sel_hold--;
      if ($urandom_range(29) == 0) run = ~run;
      if (btn_hold == 0) begin
        step_btn = ~step_btn;
        btn_hold = $urandom_range(10, 1);
      end
      btn_hold--;
      if ($urandom_range(599) == 0) begin
        reset = 1'b1;
        #2;
        chk("rnd_async_rst", outs(), 0);
        reset = 1'b0;
        model_reset();
      end
      @(posedge clk);
      model_edge(int'(sel), run, step_btn);
      #1;
      chk("rnd", outs(), 32'({m_en, m_mode, m_tick, m_db}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
